oam_dma_master: RTL and testbench
=================================

Name: oam_dma_master

Overview:
- Bus initiator that copies a 256-byte page from system RAM to a fixed destination register, in the style of the NES OAM DMA (CPU writes page number → bytes streamed to $2004).
- Drives the shared 6502-style bus: 16-bit addr, bidirectional 8-bit data, rw_n, cs_n.
- It is the master-side counterpart of the RAM responder. The responder registers its read data, so a read needs the request held for two cycles.
- Arbitration with the CPU uses a req/grant handshake.

Parameters:
- DEST_ADDR, 16'h2004, destination address written for every byte.
- XFER_LEN, 256, bytes per transfer. Legal range is 1..256; the source never crosses the page.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  one-cycle pulse that launches a transfer.
- page  input  8  source page, latched on start; source address = {page, idx[7:0]}.
- dma_req  output  1  bus request to the CPU/arbiter.
- dma_grant  input  1  bus granted; the master drives the bus only while granted.
- busy  output  1  high from acceptance of start until the done cycle inclusive.
- done  output  1  one-cycle pulse when the last byte has been written.
- addr  output  16  bus address.
- data  inout  8  bus data; driven only in the WR state, Z otherwise.
- rw_n  output  1  1 = read, 0 = write.
- cs_n  output  1  bus chip select, active low.

Behaviour:
- Reset is synchronous on rst_n=0 and applies mid-transfer too:
  - state → IDLE, idx → 0, page_q → 0;
  - dma_req=0, busy=0, done=0;
  - addr=16'h0000, rw_n=1, cs_n=1, data=Z;
  - any transfer in progress is abandoned with no done pulse.
- Bus released means cs_n=1, rw_n=1, addr=0, data=Z. The bus is released in IDLE, REQ and DONE.
- All bus outputs are registered. data is driven from a registered byte via the tristate enable (en = state==WR).
- States:
  - IDLE: if start, latch page_q=page, clear idx, go to REQ. Otherwise stay.
  - REQ: dma_req=1, busy=1.
    - If dma_grant=1, go to RD_ADDR.
  - RD_ADDR: addr={page_q, idx[7:0]}, rw_n=1, cs_n=0. Go to RD_DATA.
  - RD_DATA: same addr/rw_n/cs_n held. Responder read data is valid during this cycle; capture data into byte_q at the end-of-cycle edge. Go to WR.
  - WR: addr=DEST_ADDR, rw_n=0, cs_n=0, data=byte_q. Then:
    - if idx==XFER_LEN-1, go to DONE;
    - else increment idx; if dma_grant=1 go to RD_ADDR, else go to REQ.
  - DONE: done=1, busy=1, dma_req=0. Go to IDLE.
- dma_req stays high in RD_ADDR, RD_DATA and WR.
- Grant is checked only at byte boundaries. Loss of grant mid-byte is ignored until WR completes, so a started byte is always finished. Loss of grant at a boundary returns to REQ and releases the bus.
- Cost per byte is 3 cycles. Full 256-byte transfer with grant held: 1 REQ + 768 + 1 DONE = 770 cycles from the first busy cycle.
- start while busy is ignored; page_q is unchanged.
- start in the same cycle as the DONE state is ignored; start must be pulsed again from IDLE.
- idx is 9 bits wide; only idx[7:0] forms the source address.
- XFER_LEN=1 produces a single RD_ADDR/RD_DATA/WR sequence, then DONE.

Decomposition:
- Shared package nes_bus_pkg holds:
  - the state encoding localparams (IDLE, REQ, RD_ADDR, RD_DATA, WR, DONE);
  - the bus widths ADDR_W=16, DATA_W=8;
  - the address constant OAMDATA_ADDR=16'h2004.
- Single module; no sub-module is needed.
- The bench pairs the block with the RAM responder and a write-capture model at DEST_ADDR.

Test Plan:
- Basic transfer: RAM[$0200+i]=i^8'hA5, grant tied 1, start with page=8'h02.
  - Expected: 256 writes to $2004 with data i^8'hA5 in order.
  - busy high for 770 cycles; exactly one done pulse.
- Read timing:
  - Expected: addr=$0200 for exactly 2 cycles with cs_n=0, rw_n=1.
  - data is Z from the master in both cycles; byte captured equals RAM[$0200].
- Grant withdrawal: drop grant during byte 10's RD_DATA, restore after 5 cycles.
  - Expected: byte 10 completes, master returns to REQ with the bus released.
  - Resume at $020B; no duplicated or skipped bytes.
- Ignored start: a second start with page=8'h07 while busy.
  - Expected: source addresses stay in $02xx; single done pulse.
- Reset mid-transfer: rst_n=0 for 1 cycle at byte 100.
  - Expected: next cycle cs_n=1, rw_n=1, addr=0, dma_req=0, busy=0, no done pulse.
  - A new start with page=8'h03 reads from $0300.
- XFER_LEN=1 build: start with page=8'hFF.
  - Expected: one read of $FF00, one write to $2004.
  - done pulses in the 5th cycle after start.

Source files
------------

// File: rtl/nes_bus_pkg.sv
// Shared definitions for the 6502-style system bus: widths, well-known
// register addresses and the OAM DMA master state encoding.
package nes_bus_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    localparam logic [ADDR_W-1:0] OAMDATA_ADDR = 16'h2004;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_REQ     = 3'd1;
    localparam logic [2:0] ST_RD_ADDR = 3'd2;
    localparam logic [2:0] ST_RD_DATA = 3'd3;
    localparam logic [2:0] ST_WR      = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        REQ     = ST_REQ,
        RD_ADDR = ST_RD_ADDR,
        RD_DATA = ST_RD_DATA,
        WR      = ST_WR,
        DONE    = ST_DONE
    } dma_state_e;

endpackage

// File: rtl/oam_dma_master.sv
// OAM-style DMA bus master: copies XFER_LEN bytes of page {page,xx} to DEST_ADDR,
// three bus cycles per byte (two-cycle read from a registered responder, one write).
module oam_dma_master
    import nes_bus_pkg::*;
#(
    parameter logic [ADDR_W-1:0] DEST_ADDR = OAMDATA_ADDR,
    parameter int                XFER_LEN  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        page,
    output logic              dma_req,
    input  logic              dma_grant,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] addr,
    inout  wire  [DATA_W-1:0] data,
    output logic              rw_n,
    output logic              cs_n
);

    localparam logic [8:0] LAST_IDX = 9'(XFER_LEN - 1);

    dma_state_e        state_q, state_d;
    logic [8:0]        idx_q, idx_d;
    logic [7:0]        page_q, page_d;
    logic [DATA_W-1:0] byte_q, byte_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rw_n_q, rw_n_d;
    logic              cs_n_q, cs_n_d;
    logic              data_en_q, data_en_d;
    logic              dma_req_q, dma_req_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            page_q    <= '0;
            byte_q    <= '0;
            addr_q    <= '0;
            rw_n_q    <= 1'b1;
            cs_n_q    <= 1'b1;
            data_en_q <= 1'b0;
            dma_req_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            page_q    <= page_d;
            byte_q    <= byte_d;
            addr_q    <= addr_d;
            rw_n_q    <= rw_n_d;
            cs_n_q    <= cs_n_d;
            data_en_q <= data_en_d;
            dma_req_q <= dma_req_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Grant is only looked at in REQ and at the end of WR, so a byte once started always completes.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        page_d  = page_q;
        byte_d  = byte_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    page_d  = page;
                    idx_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (dma_grant) begin
                    state_d = RD_ADDR;
                end
            end
            RD_ADDR: begin
                state_d = RD_DATA;
            end
            RD_DATA: begin
                byte_d  = data;
                state_d = WR;
            end
            WR: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 9'd1;
                    state_d = dma_grant ? RD_ADDR : REQ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with state_q.
    always_comb begin
        addr_d    = '0;
        rw_n_d    = 1'b1;
        cs_n_d    = 1'b1;
        data_en_d = 1'b0;
        dma_req_d = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        case (state_d)
            REQ: begin
                dma_req_d = 1'b1;
                busy_d    = 1'b1;
            end
            RD_ADDR, RD_DATA: begin
                dma_req_d = 1'b1;
                busy_d    = 1'b1;
                addr_d    = {page_d, idx_d[7:0]};
                cs_n_d    = 1'b0;
            end
            WR: begin
                dma_req_d = 1'b1;
                busy_d    = 1'b1;
                addr_d    = DEST_ADDR;
                rw_n_d    = 1'b0;
                cs_n_d    = 1'b0;
                data_en_d = 1'b1;
            end
            DONE: begin
                busy_d = 1'b1;
                done_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign dma_req = dma_req_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign addr    = addr_q;
    assign rw_n    = rw_n_q;
    assign cs_n    = cs_n_q;
    assign data    = data_en_q ? byte_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_oam_dma_master.sv
// Bench for oam_dma_master: registered RAM responder plus a write-capture scoreboard
// on a full-length instance, and a cycle table on an XFER_LEN=1 instance.
module tb_oam_dma_master;
    import nes_bus_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, dma_grant;
    logic [7:0]  page;
    logic        dma_req, busy, done, rw_n, cs_n;
    logic [15:0] addr;
    wire  [7:0]  bus_data;

    logic        start2, grant2;
    logic [7:0]  page2;
    logic        dma_req2, busy2, done2, rw_n2, cs_n2;
    logic [15:0] addr2;
    wire  [7:0]  bus2_data;

    oam_dma_master #(.DEST_ADDR(16'h2004), .XFER_LEN(256)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .page(page),
        .dma_req(dma_req), .dma_grant(dma_grant), .busy(busy), .done(done),
        .addr(addr), .data(bus_data), .rw_n(rw_n), .cs_n(cs_n)
    );

    oam_dma_master #(.DEST_ADDR(16'h2004), .XFER_LEN(1)) dut_one (
        .clk(clk), .rst_n(rst_n), .start(start2), .page(page2),
        .dma_req(dma_req2), .dma_grant(grant2), .busy(busy2), .done(done2),
        .addr(addr2), .data(bus2_data), .rw_n(rw_n2), .cs_n(cs_n2)
    );

    int checks   = 0;
    int failures = 0;

    function automatic logic [7:0] ram_init(input logic [15:0] a);
        return a[7:0] ^ 8'hA5 ^ a[15:8] ^ 8'h02;
    endfunction

    task automatic checkOutput(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Registered-read responders: data appears the cycle after the address is first presented.
    logic       ram_oe_q = 1'b0, ram2_oe_q = 1'b0;
    logic [7:0] ram_q = 8'h00, ram2_q = 8'h00;
    always @(posedge clk) begin
        ram_oe_q  <= (cs_n === 1'b0) && (rw_n === 1'b1);
        ram_q     <= ram_init(addr);
        ram2_oe_q <= (cs_n2 === 1'b0) && (rw_n2 === 1'b1);
        ram2_q    <= ram_init(addr2);
    end
    assign bus_data  = (ram_oe_q && !cs_n && rw_n) ? ram_q : 8'hzz;
    assign bus2_data = (ram2_oe_q && !cs_n2 && rw_n2) ? ram2_q : 8'hzz;

    typedef struct {
        logic [15:0] src;
        logic [7:0]  data;
    } exp_t;
    exp_t sb_q[$];
    exp_t sb_e;

    logic        prev1_rd = 1'b0, prev2_rd = 1'b0;
    logic [15:0] prev1_a = 16'h0, prev2_a = 16'h0;
    int          busy_cycles = 0;
    int          done_count  = 0;

    // Each write must be preceded by a two-cycle read of the expected source address.
    always @(negedge clk) begin
        if (busy === 1'b1) busy_cycles++;
        if (done === 1'b1) done_count++;
        if (cs_n === 1'b0 && rw_n === 1'b1 && prev1_rd && prev1_a == addr)
            checkOutput("rd_data_bus", {32'h0, bus_data}, {32'h0, ram_init(addr)});
        if (cs_n === 1'b0 && rw_n === 1'b0) begin
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_write", 40'h1, 40'h0);
            end else begin
                sb_e = sb_q.pop_front();
                checkOutput("wr_addr", {24'h0, addr}, {24'h0, 16'h2004});
                checkOutput("wr_data", {32'h0, bus_data}, {32'h0, sb_e.data});
                checkOutput("rd_seq", {6'h0, prev2_rd, prev1_rd, prev2_a, prev1_a},
                            {6'h0, 2'b11, sb_e.src, sb_e.src});
            end
        end
        prev2_rd = prev1_rd;
        prev2_a  = prev1_a;
        prev1_rd = (cs_n === 1'b0) && (rw_n === 1'b1);
        prev1_a  = addr;
    end

    task automatic applyStimulus(input logic [7:0] p, input bit push);
        start = 1'b1;
        page  = p;
        if (push) begin
            for (int i = 0; i < 256; i++) begin
                sb_q.push_back('{src: {p, 8'(i)}, data: ram_init({p, 8'(i)})});
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input int limit);
        int n = 0;
        while (done_count == 0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic waitRead(input logic [15:0] a, input string name);
        bit found = 1'b0;
        for (int n = 0; n < 1000 && !found; n++) begin
            @(negedge clk);
            if (cs_n === 1'b0 && rw_n === 1'b1 && addr == a) found = 1'b1;
        end
        checkOutput(name, {39'h0, found}, 40'h1);
    endtask

    typedef struct {
        logic        start;
        logic [7:0]  page;
        logic        grant;
        logic [20:0] exp_out;
        logic        chk_data;
        logic [7:0]  exp_data;
    } vec_t;
    vec_t vecs[16];

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Out fields: {dma_req, busy, done, cs_n, rw_n, addr}
        vecs[0]  = '{1'b1, 8'hFF, 1'b1, {5'b00011, 16'h0000}, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 8'h00, 1'b1, {5'b11011, 16'h0000}, 1'b0, 8'h00};
        vecs[2]  = '{1'b0, 8'h00, 1'b1, {5'b11001, 16'hFF00}, 1'b0, 8'h00};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, {5'b11001, 16'hFF00}, 1'b1, ram_init(16'hFF00)};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, {5'b11000, 16'h2004}, 1'b1, ram_init(16'hFF00)};
        vecs[5]  = '{1'b1, 8'h11, 1'b1, {5'b01111, 16'h0000}, 1'b0, 8'h00};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, {5'b00011, 16'h0000}, 1'b0, 8'h00};
        vecs[7]  = '{1'b1, 8'h22, 1'b0, {5'b00011, 16'h0000}, 1'b0, 8'h00};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, {5'b11011, 16'h0000}, 1'b0, 8'h00};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, {5'b11011, 16'h0000}, 1'b0, 8'h00};
        vecs[10] = '{1'b0, 8'h00, 1'b1, {5'b11001, 16'h2200}, 1'b0, 8'h00};
        vecs[11] = '{1'b1, 8'h33, 1'b1, {5'b11001, 16'h2200}, 1'b1, ram_init(16'h2200)};
        vecs[12] = '{1'b0, 8'h00, 1'b1, {5'b11000, 16'h2004}, 1'b1, ram_init(16'h2200)};
        vecs[13] = '{1'b0, 8'h00, 1'b1, {5'b01111, 16'h0000}, 1'b0, 8'h00};
        vecs[14] = '{1'b0, 8'h00, 1'b1, {5'b00011, 16'h0000}, 1'b0, 8'h00};
        vecs[15] = '{1'b0, 8'h00, 1'b1, {5'b00011, 16'h0000}, 1'b0, 8'h00};

        rst_n = 1'b0; start = 1'b0; page = 8'h00; dma_grant = 1'b1;
        start2 = 1'b0; page2 = 8'h00; grant2 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("reset_state", {19'h0, dma_req, busy, done, cs_n, rw_n, addr},
                    {19'h0, 5'b00011, 16'h0000});
        checkOutput("reset_state_one", {19'h0, dma_req2, busy2, done2, cs_n2, rw_n2, addr2},
                    {19'h0, 5'b00011, 16'h0000});
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] basic transfer with ignored second start");
        busy_cycles = 0; done_count = 0;
        applyStimulus(8'h02, 1'b1);
        repeat (40) @(posedge clk);
        #1;
        applyStimulus(8'h07, 1'b0);
        waitDone(2000);
        checkOutput("basic_busy_cycles", 40'(busy_cycles), 40'd770);
        checkOutput("basic_done_count", 40'(done_count), 40'd1);
        checkOutput("basic_sb_empty", 40'(sb_q.size()), 40'd0);

        $display("[TB] grant withdrawal at byte 10");
        busy_cycles = 0; done_count = 0;
        applyStimulus(8'h02, 1'b1);
        waitRead(16'h020A, "find_byte10");
        @(posedge clk); #1;
        dma_grant = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("grant_loss_req", {19'h0, dma_req, busy, done, cs_n, rw_n, addr},
                    {19'h0, 5'b11011, 16'h0000});
        repeat (3) @(posedge clk);
        #1;
        dma_grant = 1'b1;
        waitDone(2000);
        checkOutput("grant_busy_cycles", 40'(busy_cycles), 40'd774);
        checkOutput("grant_done_count", 40'(done_count), 40'd1);
        checkOutput("grant_sb_empty", 40'(sb_q.size()), 40'd0);

        $display("[TB] reset mid-transfer at byte 100");
        busy_cycles = 0; done_count = 0;
        applyStimulus(8'h02, 1'b1);
        waitRead(16'h0264, "find_byte100");
        @(posedge clk); #1;
        rst_n = 1'b0;
        sb_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_mid", {19'h0, dma_req, busy, done, cs_n, rw_n, addr},
                    {19'h0, 5'b00011, 16'h0000});
        repeat (10) @(posedge clk);
        #1;
        checkOutput("reset_no_done", 40'(done_count), 40'd0);
        busy_cycles = 0; done_count = 0;
        applyStimulus(8'h03, 1'b1);
        waitDone(2000);
        checkOutput("restart_busy_cycles", 40'(busy_cycles), 40'd770);
        checkOutput("restart_done_count", 40'(done_count), 40'd1);
        checkOutput("restart_sb_empty", 40'(sb_q.size()), 40'd0);

        $display("[TB] single-byte instance cycle table");
        for (int v = 0; v < 16; v++) begin
            start2 = vecs[v].start;
            page2  = vecs[v].page;
            grant2 = vecs[v].grant;
            @(negedge clk);
            checkOutput($sformatf("one_vec%0d", v),
                        {19'h0, dma_req2, busy2, done2, cs_n2, rw_n2, addr2},
                        {19'h0, vecs[v].exp_out});
            if (vecs[v].chk_data)
                checkOutput($sformatf("one_data%0d", v), {32'h0, bus2_data},
                            {32'h0, vecs[v].exp_data});
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
